// File: rtl/glb_host_master.sv
// glb_host_master: host-port initiator for the global buffer with credit-limited in-order read responses
module glb_host_master #(
  parameter int RD_LATENCY = 2,
  parameter int RSP_DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_write,
  input  logic [31:0] cmd_addr,
  input  logic [63:0] cmd_data,
  input  logic [7:0]  cmd_strb,
  output logic [7:0]  host_wr_strb,
  output logic [31:0] host_wr_addr,
  output logic [63:0] host_wr_data,
  output logic        host_rd_en,
  output logic [31:0] host_rd_addr,
  input  logic [63:0] host_rd_data,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [63:0] rsp_data,
  output logic        idle
);
  localparam int AW = $clog2(RSP_DEPTH);
  localparam int PW = AW + 1;
  localparam int CW = $clog2(RSP_DEPTH + 1);
  logic [CW-1:0] cred;
  logic [RD_LATENCY-1:0] tag;
  logic [63:0] mem [RSP_DEPTH];
  logic [PW-1:0] wp, rp;
  logic accept, rd_acc, push, pop, empty;
  assign cmd_ready = cred < CW'(RSP_DEPTH);
  assign accept = cmd_valid & cmd_ready;
  assign rd_acc = accept & ~cmd_write;
  assign push = tag[RD_LATENCY-1];
  assign empty = wp == rp;
  assign rsp_valid = ~empty;
  assign pop = rsp_valid & rsp_ready;
  assign rsp_data = empty ? '0 : mem[rp[AW-1:0]];
  assign idle = (cred == '0) & ~host_rd_en & ~|host_wr_strb;
  always_ff @(posedge clk) begin
    if (reset) begin
      cred <= '0;
      tag <= '0;
      wp <= '0;
      rp <= '0;
      host_wr_strb <= '0;
      host_wr_addr <= '0;
      host_wr_data <= '0;
      host_rd_en <= 1'b0;
      host_rd_addr <= '0;
    end else begin
      cred <= cred + CW'(rd_acc) - CW'(pop);
      tag[0] <= host_rd_en;
      for (int i = 1; i < RD_LATENCY; i++) tag[i] <= tag[i-1];
      wp <= wp + PW'(push);
      rp <= rp + PW'(pop);
      host_wr_strb <= (accept & cmd_write) ? cmd_strb : '0;
      host_rd_en <= rd_acc;
      if (accept & cmd_write) begin
        host_wr_addr <= cmd_addr;
        host_wr_data <= cmd_data;
      end
      if (rd_acc) host_rd_addr <= cmd_addr;
    end
  end
  // Storage needs no reset: the pointers define what is valid.
  always_ff @(posedge clk) begin
    if (push & ~reset) mem[wp[AW-1:0]] <= host_rd_data;
  end
endmodule

// File: tb/tb_glb_host_master.sv
// tb_glb_host_master: table-driven commands, scoreboarded read data and a cycle model of the host master
module tb_glb_host_master;
  localparam int L = 2;
  localparam int D = 4;
  logic clk = 0, reset = 1;
  logic cmd_valid = 0, cmd_write = 0, rsp_ready = 1;
  logic [31:0] cmd_addr = '0;
  logic [63:0] cmd_data = '0;
  logic [7:0] cmd_strb = '0;
  logic cmd_ready, host_rd_en, rsp_valid, idle;
  logic [7:0] host_wr_strb;
  logic [31:0] host_wr_addr, host_rd_addr;
  logic [63:0] host_wr_data, host_rd_data, rsp_data;

  glb_host_master #(.RD_LATENCY(L), .RSP_DEPTH(D)) dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_write(cmd_write), .cmd_addr(cmd_addr), .cmd_data(cmd_data), .cmd_strb(cmd_strb),
    .host_wr_strb(host_wr_strb), .host_wr_addr(host_wr_addr), .host_wr_data(host_wr_data),
    .host_rd_en(host_rd_en), .host_rd_addr(host_rd_addr), .host_rd_data(host_rd_data),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .idle(idle)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit wr;
    logic [31:0] addr;
    logic [63:0] data;
    logic [7:0] strb;
    logic [63:0] exp;
  } vec_t;
  vec_t tbl [20];
  logic [63:0] sb [$];
  int checks = 0, errors = 0;

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Global buffer model: byte-strobed writes, read data valid L cycles after the strobe
  logic [63:0] gmem [logic [31:0]];
  logic [63:0] gw;
  logic [31:0] ra1;
  logic rv1 = 0;
  always @(posedge clk) begin
    if (|host_wr_strb) begin
      gw = gmem.exists(host_wr_addr) ? gmem[host_wr_addr] : '0;
      for (int b = 0; b < 8; b++) if (host_wr_strb[b]) gw[8*b +: 8] = host_wr_data[8*b +: 8];
      gmem[host_wr_addr] = gw;
    end
    rv1 <= host_rd_en;
    ra1 <= host_rd_addr;
    host_rd_data <= (rv1 && gmem.exists(ra1)) ? gmem[ra1] : 64'hBAD0_BAD0_BAD0_BAD0;
  end

  // Cycle model of credits, issue registers and FIFO occupancy, checked every cycle
  int cred_m = 0, occ = 0;
  bit m_rd_en = 0, armed = 0, acc, pop, p;
  bit hs [L];
  logic [7:0] m_strb = '0;
  logic [31:0] m_wa = '0, m_ra = '0;
  logic [63:0] m_wd = '0;
  always @(negedge clk) begin
    if (armed) begin
      chk("cmd_ready", 64'(cmd_ready), 64'(cred_m < D));
      chk("host_rd_en", 64'(host_rd_en), 64'(m_rd_en));
      chk("host_rd_addr", 64'(host_rd_addr), 64'(m_ra));
      chk("host_wr_strb", 64'(host_wr_strb), 64'(m_strb));
      chk("host_wr_addr", 64'(host_wr_addr), 64'(m_wa));
      chk("host_wr_data", host_wr_data, m_wd);
      chk("rsp_valid", 64'(rsp_valid), 64'(occ != 0));
      chk("idle", 64'(idle), 64'(cred_m == 0 && !m_rd_en && m_strb == 0));
    end
    if (!reset && rsp_valid && rsp_ready) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL rsp_unexpected: got %h expected no response", rsp_data);
      end else chk("rsp_data", rsp_data, sb.pop_front());
    end
    acc = !reset && cmd_valid && cred_m < D;
    pop = !reset && occ != 0 && rsp_ready;
    p = hs[L-1];
    if (reset) begin
      cred_m = 0;
      occ = 0;
      m_rd_en = 0;
      m_strb = '0;
      m_wa = '0;
      m_wd = '0;
      m_ra = '0;
      for (int k = 0; k < L; k++) hs[k] = 0;
      armed = 1;
    end else begin
      checks++;
      assert (!(occ == D && p && !pop)) else begin
        errors++;
        $display("FAIL fifo_overflow: got push with %0d entries, limit %0d", occ, D);
      end
      cred_m = cred_m + int'(acc && !cmd_write) - int'(pop);
      occ = occ + int'(p) - int'(pop);
      m_strb = (acc && cmd_write) ? cmd_strb : '0;
      m_rd_en = acc && !cmd_write;
      if (acc && cmd_write) begin
        m_wa = cmd_addr;
        m_wd = cmd_data;
      end
      if (acc && !cmd_write) m_ra = cmd_addr;
      for (int k = L - 1; k > 0; k--) hs[k] = hs[k-1];
      hs[0] = host_rd_en;
    end
  end

  task automatic send(bit wr, logic [31:0] a, logic [63:0] d, logic [7:0] s, logic [63:0] e);
    int n = 0;
    cmd_valid = 1;
    cmd_write = wr;
    cmd_addr = a;
    cmd_data = d;
    cmd_strb = s;
    @(negedge clk);
    while (!cmd_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!cmd_ready) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: got cmd_ready=0 for %0d cycles, expected 1", n);
    end else if (!wr) sb.push_back(e);
    @(posedge clk);
    #1 cmd_valid = 0;
  endtask

  task automatic wait_drain(string name);
    int n = 0;
    @(negedge clk);
    while ((sb.size() != 0 || !idle) && n < 60) begin
      @(negedge clk);
      n++;
    end
    chk({name, "_pending"}, 64'(sb.size()), 64'd0);
    chk({name, "_idle"}, 64'(idle), 64'd1);
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_vals(string name);
    @(negedge clk);
    chk({name, "_cmd_ready"}, 64'(cmd_ready), 64'd1);
    chk({name, "_wr_strb"}, 64'(host_wr_strb), 64'd0);
    chk({name, "_wr_addr"}, 64'(host_wr_addr), 64'd0);
    chk({name, "_wr_data"}, host_wr_data, 64'd0);
    chk({name, "_rd_en"}, 64'(host_rd_en), 64'd0);
    chk({name, "_rd_addr"}, 64'(host_rd_addr), 64'd0);
    chk({name, "_rsp_valid"}, 64'(rsp_valid), 64'd0);
    chk({name, "_rsp_data"}, rsp_data, 64'd0);
    chk({name, "_idle"}, 64'(idle), 64'd1);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, expected end of test");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, k, c, seen;
    for (int i = 0; i < 8; i++) begin
      tbl[i] = '{1'b1, 32'(8 * i), 64'(32'h100 + i), 8'hFF, 64'd0};
      tbl[8+i] = '{1'b0, 32'(8 * i), 64'd0, 8'h00, 64'(32'h100 + i)};
    end
    tbl[16] = '{1'b1, 32'h40, 64'h1111_1111_1111_1111, 8'hFF, 64'd0};
    tbl[17] = '{1'b1, 32'h40, 64'h2222_2222_2222_2222, 8'h0F, 64'd0};
    tbl[18] = '{1'b1, 32'h40, 64'h3333_3333_3333_3333, 8'h00, 64'd0};
    tbl[19] = '{1'b0, 32'h40, 64'd0, 8'h00, 64'h1111_1111_2222_2222};
    repeat (3) @(posedge clk);
    #1 reset = 0;
    check_reset_vals("por");
    send(1'b1, 32'hF, 64'h1234_5678, 8'hFF, 64'd0);
    @(negedge clk);
    chk("w1_strb", 64'(host_wr_strb), 64'hFF);
    chk("w1_addr", 64'(host_wr_addr), 64'hF);
    chk("w1_data", host_wr_data, 64'h1234_5678);
    chk("w1_rsp_valid", 64'(rsp_valid), 64'd0);
    @(negedge clk);
    chk("w1_strb_off", 64'(host_wr_strb), 64'd0);
    @(posedge clk);
    #1 send(1'b0, 32'hF, 64'd0, 8'h00, 64'h1234_5678);
    @(negedge clk);
    chk("r1_rd_en", 64'(host_rd_en), 64'd1);
    chk("r1_rd_addr", 64'(host_rd_addr), 64'hF);
    n = 0;
    while (!rsp_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("r1_turnaround", 64'(n), 64'(L + 1));
    chk("r1_data", rsp_data, 64'h1234_5678);
    @(posedge clk);
    #1 wait_drain("r1");
    for (int i = 0; i < 20; i++) send(tbl[i].wr, tbl[i].addr, tbl[i].data, tbl[i].strb, tbl[i].exp);
    wait_drain("table");
    rsp_ready = 0;
    k = 0;
    cmd_valid = 1;
    cmd_write = 0;
    cmd_addr = 32'h0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (cmd_ready) begin
        sb.push_back(64'(32'h100 + k));
        k++;
      end
      @(posedge clk);
      #1 cmd_addr = 32'(8 * k);
    end
    @(negedge clk);
    chk("bp_accepted", 64'(k), 64'(D));
    chk("bp_cmd_ready", 64'(cmd_ready), 64'd0);
    chk("bp_idle", 64'(idle), 64'd0);
    @(posedge clk);
    #1 rsp_ready = 1;
    c = 0;
    while (k < 6 && c < 30) begin
      @(negedge clk);
      if (cmd_ready) begin
        sb.push_back(64'(32'h100 + k));
        k++;
      end
      @(posedge clk);
      #1 cmd_addr = 32'(8 * k);
      c++;
    end
    cmd_valid = 0;
    chk("bp_total", 64'(k), 64'd6);
    wait_drain("bp");
    send(1'b0, 32'h40, 64'd0, 8'h00, 64'h1111_1111_2222_2222);
    @(posedge clk);
    #1;
    @(posedge clk);
    #1 reset = 1;
    sb.delete();
    @(posedge clk);
    #1 reset = 0;
    check_reset_vals("mid_reset");
    seen = 0;
    repeat (6) begin
      @(negedge clk);
      if (rsp_valid) seen++;
    end
    chk("flushed_rsp", 64'(seen), 64'd0);
    @(posedge clk);
    #1 send(1'b0, 32'hF, 64'd0, 8'h00, 64'h1234_5678);
    wait_drain("fresh");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
